// File: rtl/seg7_readback.sv
// seg7_readback
// Decodes the active-low tens/ones segment buses of the tally display back
// into a binary value so the display path can be self-checked. A pattern must
// hold unchanged for STABLE_CYCLES clocks before it is decoded. Each decode
// raises a one-cycle update strobe and advances a wrapping update counter.
//
// Parameters
//   STABLE_CYCLES  unchanged cycles needed before a decode (1..255)
//   CNT_W          width of upd_cnt
// Ports
//   clk      in   rising-edge system clock
//   rst_n    in   asynchronous active-low reset
//   seg_t    in   [6:0] tens-digit segments, active-low, bit6=g .. bit0=a
//   seg_o    in   [6:0] ones-digit segments, same encoding
//   value    out  [6:0] last successfully decoded value, 0..99
//   upd      out  one-cycle pulse when a stable pattern has been decoded
//   err      out  last stable pattern held a non-digit in either position
//   stable   out  current input has passed the stability filter
//   upd_cnt  out  [CNT_W-1:0] count of upd pulses since reset, wraps
module seg7_readback #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       seg_t,
   input  logic [6:0]       seg_o,
   output logic [6:0]       value,
   output logic             upd,
   output logic             err,
   output logic             stable,
   output logic [CNT_W-1:0] upd_cnt
);

   typedef enum logic {SETTLE, STABLE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   state_t           state, state_next;
   logic [6:0]       last_t, last_t_next;
   logic [6:0]       last_o, last_o_next;
   logic [7:0]       cnt, cnt_next;
   logic [6:0]       value_next;
   logic             upd_next;
   logic             err_next;
   logic             stable_next;
   logic [CNT_W-1:0] upd_cnt_next;
   logic [4:0]       dec_t, dec_o;
   logic             changed;

   // Returns {valid, digit}; anything outside the ten digit glyphs is invalid.
   function automatic logic [4:0] decode_digit(input logic [6:0] seg);
      case (seg)
         7'b1000000: decode_digit = {1'b1, 4'd0};
         7'b1111001: decode_digit = {1'b1, 4'd1};
         7'b0100100: decode_digit = {1'b1, 4'd2};
         7'b0110000: decode_digit = {1'b1, 4'd3};
         7'b0011001: decode_digit = {1'b1, 4'd4};
         7'b0010010: decode_digit = {1'b1, 4'd5};
         7'b0000010: decode_digit = {1'b1, 4'd6};
         7'b1111000: decode_digit = {1'b1, 4'd7};
         7'b0000000: decode_digit = {1'b1, 4'd8};
         7'b0010000: decode_digit = {1'b1, 4'd9};
         default:    decode_digit = 5'b0_0000;
      endcase
   endfunction

   // Decoding the latched copy is equivalent to decoding the inputs whenever
   // no change is seen, which is the only time the result is used.
   assign dec_t   = decode_digit(last_t);
   assign dec_o   = decode_digit(last_o);
   assign changed = ({seg_t, seg_o} != {last_t, last_o});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= SETTLE;
         last_t  <= 7'h7F;
         last_o  <= 7'h7F;
         cnt     <= 8'd0;
         value   <= 7'd0;
         upd     <= 1'b0;
         err     <= 1'b0;
         stable  <= 1'b0;
         upd_cnt <= '0;
      end else begin
         state   <= state_next;
         last_t  <= last_t_next;
         last_o  <= last_o_next;
         cnt     <= cnt_next;
         value   <= value_next;
         upd     <= upd_next;
         err     <= err_next;
         stable  <= stable_next;
         upd_cnt <= upd_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      last_t_next  = last_t;
      last_o_next  = last_o;
      cnt_next     = cnt;
      value_next   = value;
      upd_next     = 1'b0;
      err_next     = err;
      stable_next  = stable;
      upd_cnt_next = upd_cnt;

      if (changed) begin
         // Any movement on the buses restarts the filter, whatever the state.
         last_t_next = seg_t;
         last_o_next = seg_o;
         cnt_next    = 8'd0;
         state_next  = SETTLE;
         stable_next = 1'b0;
      end else begin
         case (state)
            SETTLE: begin
               if (cnt == CNT_LAST) begin
                  state_next   = STABLE;
                  stable_next  = 1'b1;
                  upd_next     = 1'b1;
                  upd_cnt_next = upd_cnt + 1'b1;
                  if (dec_t[4] && dec_o[4]) begin
                     value_next = 7'(dec_t[3:0]) * 7'd10 + 7'(dec_o[3:0]);
                     err_next   = 1'b0;
                  end else begin
                     err_next   = 1'b1;
                  end
               end else begin
                  cnt_next = cnt + 8'd1;
               end
            end
            STABLE: begin
               // Pattern already reported; hold everything.
            end
            default: state_next = SETTLE;
         endcase
      end
   end

endmodule
